// File: rtl/rgb_fade_ctrl.sv
// rtl/rgb_fade_ctrl.sv - frame-aligned RGB fade sequencer driving three pwm level inputs
//
// Optional feature macro: GAMMA_EN (registered gamma-corrected level outputs,
// level_x = (lin_x * lin_x) >> 8, one extra cycle of latency).
//
// Ports:
//   clk                   system clock
//   reset                 asynchronous active-high reset
//   cmd_valid, cmd_ready  command handshake (accepted when both high at posedge)
//   cmd_r, cmd_g, cmd_b   target levels
//   cmd_div               frames per step, 0 = jump straight to target
//   level_r/g/b           levels to the pwm channels
//   busy                  fade in progress
//   done                  one-cycle pulse when a fade completes
module rgb_fade_ctrl #(
   parameter int WIDTH     = 8,
   parameter int DIV_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [7:0]           cmd_r,
   input  logic [7:0]           cmd_g,
   input  logic [7:0]           cmd_b,
   input  logic [DIV_WIDTH-1:0] cmd_div,
   output logic [7:0]           level_r,
   output logic [7:0]           level_g,
   output logic [7:0]           level_b,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic {IDLE, FADE} state_t;

   localparam logic [WIDTH-1:0]     FRAME_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [DIV_WIDTH-1:0] DIV_ONE   = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

   state_t               state;
   logic [WIDTH-1:0]     frame_cnt;
   logic                 frame_tick;
   logic [DIV_WIDTH-1:0] div;
   logic [DIV_WIDTH-1:0] prescaler;
   logic [7:0]           tgt_r, tgt_g, tgt_b;
   logic [7:0]           lin_r, lin_g, lin_b;
   logic [7:0]           nxt_r, nxt_g, nxt_b;
   logic                 step_now;
   logic                 all_match;

   // Move one LSB toward the target; never overshoots, so no wrap at 0/255.
   function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
      if (cur < tgt)
         return cur + 8'd1;
      else if (cur > tgt)
         return cur - 8'd1;
      else
         return cur;
   endfunction

   // Last clock of the pwm period: a level written here is seen from pwm counter 0.
   assign frame_tick = &frame_cnt;
   assign step_now   = (div == '0) || (prescaler == div - DIV_ONE);

   always_comb begin
      nxt_r = lin_r;
      nxt_g = lin_g;
      nxt_b = lin_b;
      if (div == '0) begin
         nxt_r = tgt_r;
         nxt_g = tgt_g;
         nxt_b = tgt_b;
      end else begin
         nxt_r = step_toward(lin_r, tgt_r);
         nxt_g = step_toward(lin_g, tgt_g);
         nxt_b = step_toward(lin_b, tgt_b);
      end
   end

   assign all_match = (nxt_r == tgt_r) && (nxt_g == tgt_g) && (nxt_b == tgt_b);

   // Shares the pwm reset so it stays phase-locked to the pwm counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         frame_cnt <= '0;
      else
         frame_cnt <= frame_cnt + FRAME_ONE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         div       <= '0;
         prescaler <= '0;
         tgt_r     <= 8'd0;
         tgt_g     <= 8'd0;
         tgt_b     <= 8'd0;
         lin_r     <= 8'd0;
         lin_g     <= 8'd0;
         lin_b     <= 8'd0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  tgt_r     <= cmd_r;
                  tgt_g     <= cmd_g;
                  tgt_b     <= cmd_b;
                  div       <= cmd_div;
                  prescaler <= '0;
                  busy      <= 1'b1;
                  cmd_ready <= 1'b0;
                  state     <= FADE;
               end
            end
            FADE: begin
               // New commands are neither queued nor allowed to abort the fade.
               if (frame_tick) begin
                  if (step_now) begin
                     prescaler <= '0;
                     lin_r     <= nxt_r;
                     lin_g     <= nxt_g;
                     lin_b     <= nxt_b;
                     if (all_match) begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                     end
                  end else begin
                     prescaler <= prescaler + DIV_ONE;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               cmd_ready <= 1'b1;
            end
         endcase
      end
   end

`ifdef GAMMA_EN
   logic [15:0] sq_r, sq_g, sq_b;

   assign sq_r = lin_r * lin_r;
   assign sq_g = lin_g * lin_g;
   assign sq_b = lin_b * lin_b;

   // Squared levels, upper byte only; lands one clock after the linear update.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level_r <= 8'd0;
         level_g <= 8'd0;
         level_b <= 8'd0;
      end else begin
         level_r <= sq_r[15:8];
         level_g <= sq_g[15:8];
         level_b <= sq_b[15:8];
      end
   end
`else
   assign level_r = lin_r;
   assign level_g = lin_g;
   assign level_b = lin_b;
`endif

endmodule
